// File: rtl/epc_stack.sv
// epc_stack: nested exception-PC stack with a registered ERET return PC.
// Build macro EPC_STACK_STATS_EN adds the saturating exc_count output.
module epc_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int STEP  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         exc_req,
   input  logic [WIDTH-1:0]             exc_pc,
   input  logic                         exc_bd,
   input  logic                         exc_skip,
   input  logic                         eret_req,
   output logic [WIDTH-1:0]             epc_top,
   output logic                         bd_top,
   output logic [WIDTH-1:0]             ret_pc,
   output logic                         ret_valid,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         in_handler,
   output logic                         fault
`ifdef EPC_STACK_STATS_EN
   ,output logic [15:0]                 exc_count
`endif
);

   localparam int DW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FAULT  = 2'd2;

   logic [WIDTH-1:0] epc_r   [DEPTH];
   logic [WIDTH-1:0] epc_n_s [DEPTH];
   logic [DEPTH-1:0] bd_r, bd_n_s;
   logic [DEPTH-1:0] skip_r, skip_n_s;
   logic [DW-1:0]    depth_r, depth_n_s;
   logic [1:0]       state_r, state_n_s;
   logic [WIDTH-1:0] ret_pc_n_s;
   logic             ret_valid_n_s;
   logic [WIDTH-1:0] new_epc_s;
   logic [AW-1:0]    wr_idx_s, top_idx_s, nxt_top_idx_s;
   logic [WIDTH-1:0] epc_top_n_s;
   logic             bd_top_n_s;

   assign new_epc_s     = exc_bd ? (exc_pc - STEP_W) : exc_pc;
   assign wr_idx_s      = AW'(depth_r);
   assign top_idx_s     = AW'(depth_r - DW'(1));
   assign nxt_top_idx_s = AW'(depth_n_s - DW'(1));

   // Next-state: push, pop, replace and fault transitions of the stack.
   always_comb begin
      epc_n_s       = epc_r;
      bd_n_s        = bd_r;
      skip_n_s      = skip_r;
      depth_n_s     = depth_r;
      state_n_s     = state_r;
      ret_pc_n_s    = ret_pc;
      ret_valid_n_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            // With an empty stack a simultaneous ERET does not count; it is a plain push.
            if (exc_req) begin
               epc_n_s[0]  = new_epc_s;
               bd_n_s[0]   = exc_bd;
               skip_n_s[0] = exc_skip;
               depth_n_s   = DW'(1);
               state_n_s   = ST_ACTIVE;
            end else if (eret_req) begin
               state_n_s = ST_FAULT;
            end else begin
               state_n_s = ST_EMPTY;
            end
         end
         ST_ACTIVE: begin
            if (exc_req && eret_req) begin
               epc_n_s[top_idx_s]  = new_epc_s;
               bd_n_s[top_idx_s]   = exc_bd;
               skip_n_s[top_idx_s] = exc_skip;
            end else if (exc_req) begin
               if (depth_r == DEPTH_W) begin
                  state_n_s = ST_FAULT;
               end else begin
                  epc_n_s[wr_idx_s]  = new_epc_s;
                  bd_n_s[wr_idx_s]   = exc_bd;
                  skip_n_s[wr_idx_s] = exc_skip;
                  depth_n_s          = depth_r + DW'(1);
               end
            end else if (eret_req) begin
               ret_pc_n_s    = skip_r[top_idx_s] ? (epc_r[top_idx_s] + STEP_W) : epc_r[top_idx_s];
               ret_valid_n_s = 1'b1;
               depth_n_s     = depth_r - DW'(1);
               if (depth_r == DW'(1)) begin
                  state_n_s = ST_EMPTY;
               end else begin
                  state_n_s = ST_ACTIVE;
               end
            end else begin
               state_n_s = ST_ACTIVE;
            end
         end
         ST_FAULT: begin
            state_n_s = ST_FAULT;
         end
         default: begin
            state_n_s = ST_FAULT;
         end
      endcase
      if (depth_n_s == {DW{1'b0}}) begin
         epc_top_n_s = {WIDTH{1'b0}};
         bd_top_n_s  = 1'b0;
      end else begin
         epc_top_n_s = epc_n_s[nxt_top_idx_s];
         bd_top_n_s  = bd_n_s[nxt_top_idx_s];
      end
   end

   // State and output registers; reset overrides any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            epc_r[i] <= {WIDTH{1'b0}};
         end
         bd_r       <= {DEPTH{1'b0}};
         skip_r     <= {DEPTH{1'b0}};
         depth_r    <= {DW{1'b0}};
         state_r    <= ST_EMPTY;
         epc_top    <= {WIDTH{1'b0}};
         bd_top     <= 1'b0;
         ret_pc     <= {WIDTH{1'b0}};
         ret_valid  <= 1'b0;
         in_handler <= 1'b0;
         fault      <= 1'b0;
      end else begin
         epc_r      <= epc_n_s;
         bd_r       <= bd_n_s;
         skip_r     <= skip_n_s;
         depth_r    <= depth_n_s;
         state_r    <= state_n_s;
         epc_top    <= epc_top_n_s;
         bd_top     <= bd_top_n_s;
         ret_pc     <= ret_pc_n_s;
         ret_valid  <= ret_valid_n_s;
         in_handler <= (depth_n_s != {DW{1'b0}});
         fault      <= (state_n_s == ST_FAULT);
      end
   end

   assign depth = depth_r;

`ifdef EPC_STACK_STATS_EN
   logic        push_cnt_s;
   logic [15:0] exc_count_r;

   assign push_cnt_s = exc_req &&
                       ((state_r == ST_EMPTY) ||
                        ((state_r == ST_ACTIVE) && (eret_req || (depth_r != DEPTH_W))));

   // Saturating count of accepted pushes, replacements included.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_count_r <= 16'd0;
      end else if (push_cnt_s && (exc_count_r != 16'hFFFF)) begin
         exc_count_r <= exc_count_r + 16'd1;
      end else begin
         exc_count_r <= exc_count_r;
      end
   end

   assign exc_count = exc_count_r;
`endif

endmodule

// File: tb/tb_epc_stack.sv
// tb_epc_stack: directed cases plus randomized traffic against a queue-based
// reference model of the exception-PC stack.
module tb_epc_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int STEP  = 4;

   logic              clk = 1'b0;
   logic              rst, exc_req, exc_bd, exc_skip, eret_req;
   logic [WIDTH-1:0]  exc_pc;
   logic [WIDTH-1:0]  epc_top, ret_pc;
   logic              bd_top, ret_valid, in_handler, fault;
   logic [$clog2(DEPTH+1)-1:0] depth;
`ifdef EPC_STACK_STATS_EN
   logic [15:0]       exc_count;
`endif

   epc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(STEP)) dut (
      .clk(clk), .rst(rst), .exc_req(exc_req), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .exc_skip(exc_skip), .eret_req(eret_req), .epc_top(epc_top), .bd_top(bd_top),
      .ret_pc(ret_pc), .ret_valid(ret_valid), .depth(depth), .in_handler(in_handler),
      .fault(fault)
`ifdef EPC_STACK_STATS_EN
      , .exc_count(exc_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] epc;
      logic        bd;
      logic        skip;
   } ent_t;

   ent_t        q[$];
   bit          m_fault;
   logic [31:0] m_ret_pc;
   bit          m_rv;
   int          m_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: stack of entries as a queue; the back of the queue is the top.
   task automatic model_update();
      ent_t ne, e;
      ne.epc  = exc_bd ? (exc_pc - 32'(STEP)) : exc_pc;
      ne.bd   = exc_bd;
      ne.skip = exc_skip;
      m_rv    = 1'b0;
      if (rst) begin
         q.delete();
         m_fault  = 1'b0;
         m_ret_pc = 32'd0;
         m_cnt    = 0;
      end else if (!m_fault) begin
         if (exc_req && eret_req && q.size() > 0) begin
            q[q.size()-1] = ne;
            if (m_cnt < 65535) m_cnt++;
         end else if (exc_req) begin
            if (q.size() == DEPTH) m_fault = 1'b1;
            else begin
               q.push_back(ne);
               if (m_cnt < 65535) m_cnt++;
            end
         end else if (eret_req) begin
            if (q.size() == 0) m_fault = 1'b1;
            else begin
               e        = q.pop_back();
               m_ret_pc = e.skip ? (e.epc + 32'(STEP)) : e.epc;
               m_rv     = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] exp_epc;
      logic        exp_bd;
      exp_epc = (q.size() > 0) ? q[q.size()-1].epc : 32'd0;
      exp_bd  = (q.size() > 0) ? q[q.size()-1].bd  : 1'b0;
      check_eq("epc_top",    epc_top,         exp_epc);
      check_eq("bd_top",     32'(bd_top),     32'(exp_bd));
      check_eq("depth",      32'(depth),      32'(q.size()));
      check_eq("in_handler", 32'(in_handler), 32'(q.size() != 0));
      check_eq("fault",      32'(fault),      32'(m_fault));
      check_eq("ret_valid",  32'(ret_valid),  32'(m_rv));
      check_eq("ret_pc",     ret_pc,          m_ret_pc);
`ifdef EPC_STACK_STATS_EN
      check_eq("exc_count",  32'(exc_count),  32'(m_cnt));
`endif
   endtask

   task automatic cyc(input bit r, input bit e, input logic [31:0] pc,
                      input bit bd, input bit sk, input bit er);
      rst = r; exc_req = e; exc_pc = pc; exc_bd = bd; exc_skip = sk; eret_req = er;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic push(input logic [31:0] pc, input bit bd, input bit sk);
      cyc(1'b0, 1'b1, pc, bd, sk, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; exc_req = 1'b0; exc_pc = 32'd0; exc_bd = 1'b0; exc_skip = 1'b0; eret_req = 1'b0;
      m_fault = 1'b0; m_ret_pc = 32'd0; m_rv = 1'b0; m_cnt = 0;
      do_reset();
      do_reset();
      check_eq("reset_depth", 32'(depth), 32'd0);
      check_eq("reset_fault", 32'(fault), 32'd0);

      // Plain push / restart return
      push(32'h0040_0010, 1'b0, 1'b0);
      check_eq("t1_epc_top", epc_top, 32'h0040_0010);
      check_eq("t1_depth1", 32'(depth), 32'd1);
      pop();
      check_eq("t1_ret_pc", ret_pc, 32'h0040_0010);
      check_eq("t1_ret_valid", 32'(ret_valid), 32'd1);
      check_eq("t1_depth0", 32'(depth), 32'd0);
      idle();
      check_eq("t1_rv_pulse", 32'(ret_valid), 32'd0);

      // Delay-slot adjust
      push(32'h0040_0024, 1'b1, 1'b0);
      check_eq("t2_epc_top", epc_top, 32'h0040_0020);
      check_eq("t2_bd_top", 32'(bd_top), 32'd1);
      pop();
      check_eq("t2_ret_pc", ret_pc, 32'h0040_0020);

      // Skip return and modulo wrap
      push(32'h0040_0100, 1'b0, 1'b1);
      pop();
      check_eq("t3_ret_skip", ret_pc, 32'h0040_0104);
      push(32'hFFFF_FFFC, 1'b0, 1'b1);
      pop();
      check_eq("t3_ret_wrap", ret_pc, 32'h0000_0000);
      push(32'h0000_0000, 1'b1, 1'b0);
      check_eq("t3_bd_wrap", epc_top, 32'hFFFF_FFFC);
      pop();

      // Overflow
      push(32'h0000_1000, 1'b0, 1'b0);
      push(32'h0000_2000, 1'b0, 1'b0);
      push(32'h0000_3000, 1'b0, 1'b0);
      push(32'h0000_4000, 1'b0, 1'b0);
      push(32'h0000_5000, 1'b0, 1'b0);
      check_eq("t4_fault", 32'(fault), 32'd1);
      check_eq("t4_depth", 32'(depth), 32'd4);
      check_eq("t4_epc_top", epc_top, 32'h0000_4000);
      pop();
      check_eq("t4_no_rv", 32'(ret_valid), 32'd0);
      do_reset();

      // Replacement and underflow
      push(32'h0000_0100, 1'b0, 1'b0);
      push(32'h0000_0200, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b1);
      check_eq("t5_depth", 32'(depth), 32'd2);
      check_eq("t5_top", epc_top, 32'h0000_0300);
      check_eq("t5_no_rv", 32'(ret_valid), 32'd0);
      pop();
      check_eq("t5_ret_pc", ret_pc, 32'h0000_0304);
      pop();
      pop();
      check_eq("t5_underflow", 32'(fault), 32'd1);
      do_reset();

      // Reset mid-handler wins over ERET
      push(32'h0000_0A00, 1'b1, 1'b0);
      push(32'h0000_0B00, 1'b0, 1'b0);
      push(32'h0000_0C00, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      check_eq("t6_depth", 32'(depth), 32'd0);
      check_eq("t6_epc_top", epc_top, 32'd0);
      check_eq("t6_ret_valid", 32'(ret_valid), 32'd0);
      check_eq("t6_in_handler", 32'(in_handler), 32'd0);
`ifdef EPC_STACK_STATS_EN
      check_eq("t6_exc_count", 32'(exc_count), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit          r, e, er, bd, sk;
         logic [31:0] pc;
         r  = m_fault ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
         e  = ($urandom_range(0, 99) < 40);
         er = ($urandom_range(0, 99) < 35);
         bd = $urandom_range(0, 1) == 1;
         sk = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0:       pc = 32'h0000_0000;
            1:       pc = 32'hFFFF_FFFC;
            default: pc = $urandom;
         endcase
         cyc(r, e, pc, bd, sk, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
